// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle for one pipeline stage boundary.
interface pipe_stage_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Valid/ready stage register with flush and backpressure.
// PIPE_STAGE_SKID_EN adds a skid entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  pipe_stage_if.slave  in_if,
  pipe_stage_if.master out_if,
  output logic [1:0]   count
);

  logic             main_v_q, main_v_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             xfer_in, xfer_out;

  assign xfer_in  = in_if.valid & in_if.ready;
  assign xfer_out = main_v_q & out_if.ready;

  assign out_if.valid = main_v_q;
  assign out_if.data  = main_data_q;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;

  assign in_if.ready = in_ready_q;
  assign count       = {1'b0, main_v_q} + {1'b0, skid_v_q};

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_v_d    = 1'b0;
      main_data_d = RESET_VAL;
      skid_v_d    = 1'b0;
    end else if (xfer_out && skid_v_q) begin
      main_data_d = skid_data_q;
      skid_v_d    = 1'b0;
    end else if (xfer_out && !xfer_in) begin
      main_v_d    = 1'b0;
      main_data_d = RESET_VAL;
    end else if (xfer_in && (xfer_out || !main_v_q)) begin
      main_v_d    = 1'b1;
      main_data_d = in_if.data;
    end else if (xfer_in) begin
      skid_v_d    = 1'b1;
      skid_data_d = in_if.data;
    end
    // ready next cycle depends only on stored state
    in_ready_d = !skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      main_data_q <= RESET_VAL;
      skid_v_q    <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      skid_v_q    <= skid_v_d;
      in_ready_q  <= in_ready_d;
    end
    skid_data_q <= skid_data_d;
  end
`else
  assign in_if.ready = !main_v_q | out_if.ready;
  assign count       = {1'b0, main_v_q};

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    if (flush) begin
      main_v_d    = 1'b0;
      main_data_d = RESET_VAL;
    end else if (xfer_in) begin
      main_v_d    = 1'b1;
      main_data_d = in_if.data;
    end else if (xfer_out) begin
      main_v_d    = 1'b0;
      main_data_d = RESET_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      main_data_q <= RESET_VAL;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg, both build flavours.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, flush;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_if #(.WIDTH(64)) in0 ();
  pipe_stage_if #(.WIDTH(64)) out0 ();
  pipe_stage_if #(.WIDTH(1))  in1 ();
  pipe_stage_if #(.WIDTH(1))  out1 ();
  pipe_stage_if #(.WIDTH(96)) in2 ();
  pipe_stage_if #(.WIDTH(96)) out2 ();
  logic [1:0] cnt0, cnt1, cnt2;

  pipe_stage_reg #(.WIDTH(64)) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_if(in0), .out_if(out0), .count(cnt0)
  );
  pipe_stage_reg #(.WIDTH(1), .RESET_VAL(1'b1)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_if(in1), .out_if(out1), .count(cnt1)
  );
  pipe_stage_reg #(.WIDTH(96), .RESET_VAL(96'h13)) u2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_if(in2), .out_if(out2), .count(cnt2)
  );

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic v,
                      input logic [63:0] d, input logic [1:0] c);
    check({tag, ".valid"}, 128'(out0.valid), 128'(v));
    check({tag, ".data"},  128'(out0.data),  128'(d));
    check({tag, ".count"}, 128'(cnt0),       128'(c));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    in0.valid = 1'b1; in0.data = 64'hDEAD; out0.ready = 1'b0;
    in1.valid = 1'b0; in1.data = 1'b0;     out1.ready = 1'b0;
    in2.valid = 1'b0; in2.data = '0;       out2.ready = 1'b0;
    tick(); tick();
    rst = 1'b0; in0.valid = 1'b0;
    #1;
    chk0("reset", 1'b0, 64'h0, 2'd0);
    check("reset.in_ready", 128'(in0.ready), 128'd1);
    check("reset.w1", 128'(out1.data), 128'h1);
    check("reset.w96", 128'(out2.data), 128'h13);

    // streaming at full rate
    out0.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in0.valid = 1'b1; in0.data = 64'(i);
      tick();
      chk0($sformatf("stream%0d", i), 1'b1, 64'(i), 2'd1);
    end
    in0.valid = 1'b0;
    tick();
    chk0("stream.end", 1'b0, 64'h0, 2'd0);

    // stall with 0xA, 0xB, 0xC
    out0.ready = 1'b0; in0.valid = 1'b1; in0.data = 64'hA;
    #1 check("stall.rdyA", 128'(in0.ready), 128'd1);
    tick();
    in0.data = 64'hB;
    #1 check("stall.rdyB", 128'(in0.ready), 128'(SKID));
    tick();
    in0.data = 64'hC;
    #1 check("stall.rdyC", 128'(in0.ready), 128'd0);
    tick();
    chk0("stall.hold", 1'b1, 64'hA, SKID ? 2'd2 : 2'd1);
    check("stall.rdy", 128'(in0.ready), 128'd0);
    in0.valid = 1'b0; out0.ready = 1'b1;
    tick();
    if (SKID) begin
      chk0("drain.B", 1'b1, 64'hB, 2'd1);
      tick();
    end
    chk0("drain.end", 1'b0, 64'h0, 2'd0);

    // flush with stage full and a beat arriving
    out0.ready = 1'b0; in0.valid = 1'b1; in0.data = 64'h11;
    tick();
    in0.data = 64'h22;
    tick();
    chk0("fill", 1'b1, 64'h11, SKID ? 2'd2 : 2'd1);
    flush = 1'b1; in0.data = 64'h55;
    tick();
    flush = 1'b0; in0.valid = 1'b0;
    chk0("flush", 1'b0, 64'h0, 2'd0);
    tick();
    chk0("flush.after", 1'b0, 64'h0, 2'd0);

    // flush held with input pending keeps it empty
    flush = 1'b1; in0.valid = 1'b1; in0.data = 64'h66;
    tick(); tick();
    chk0("flush.held", 1'b0, 64'h0, 2'd0);
    flush = 1'b0; in0.valid = 1'b0;

    // simultaneous in/out with main full
    in0.valid = 1'b1; in0.data = 64'h66;
    tick();
    out0.ready = 1'b1; in0.data = 64'h77;
    #1 check("simul.rdy", 128'(in0.ready), 128'd1);
    tick();
    chk0("simul", 1'b1, 64'h77, 2'd1);
    in0.valid = 1'b0;
    tick();
    chk0("simul.end", 1'b0, 64'h0, 2'd0);

    // rst and flush together mid-stall
    out0.ready = 1'b0; in0.valid = 1'b1; in0.data = 64'h88;
    tick();
    in0.data = 64'h99;
    tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in0.valid = 1'b0;
    chk0("rstflush", 1'b0, 64'h0, 2'd0);

    // width sweep: reset value after flush and after drain
    in1.valid = 1'b1; in1.data = 1'b0;
    in2.valid = 1'b1; in2.data = 96'hABCD_0000_0000_1234_5678;
    tick();
    check("w1.head", 128'(out1.data), 128'h0);
    check("w96.head", 128'(out2.data), 128'hABCD_0000_0000_1234_5678);
    check("w96.valid", 128'(out2.valid), 128'd1);
    in1.valid = 1'b0; in2.valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("w1.flush", 128'(out1.data), 128'h1);
    check("w96.flush", 128'(out2.data), 128'h13);
    check("w96.fvalid", 128'(out2.valid), 128'd0);
    in1.valid = 1'b1; in2.valid = 1'b1; in2.data = 96'h42;
    tick();
    check("w96.head2", 128'(out2.data), 128'h42);
    in1.valid = 1'b0; in2.valid = 1'b0;
    out1.ready = 1'b1; out2.ready = 1'b1;
    tick();
    check("w1.drain", 128'(out1.data), 128'h1);
    check("w96.drain", 128'(out2.data), 128'h13);
    check("w96.cnt", 128'(cnt2), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
